updown_mod_counter: RTL and testbench

//  Parametrised up/down counter with programmable modulus, step size, sync load/clear and

---
 rtl/fpu_cnt_pkg.sv | 17 +
 rtl/updown_mod_counter_next.sv | 63 ++++++
 rtl/updown_mod_counter.sv | 90 +++++++++
 tb/tb_updown_mod_counter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_cnt_pkg.sv
// Shared types for the FPU iteration/shift-count sequencer counter.
// Mode selector and the per-step ovf/unf event pair.
package fpu_cnt_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  typedef struct packed {
    logic ovf;
    logic unf;
  } cnt_evt_t;

  localparam cnt_evt_t CntEvtNone = '{ovf: 1'b0, unf: 1'b0};

endpackage

// File: rtl/updown_mod_counter_next.sv
// Combinational next-count for one enabled step: modulo wrap or saturate at 0/limit,
// reporting the overflow/underflow event that step produces.
module updown_mod_counter_next
  import fpu_cnt_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STEP_W = 4
) (
  input  logic [WIDTH-1:0]  q_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  limit_i,
  input  logic              down_i,
  input  cnt_mode_e         mode_i,
  output logic [WIDTH-1:0]  next_q_o,
  output cnt_evt_t          evt_o
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] step_w;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] wrap_dn;
  logic             out_of_range;
  logic             is_sat;

  // Up-sum keeps the carry so a sum past 2**WIDTH-1 still compares correctly.
  assign sum_ext      = {1'b0, q_i} + (WIDTH+1)'(step_i);
  assign step_w       = WIDTH'(step_i);
  // Only the low WIDTH bits of the wrapped results are ever kept, so modular
  // arithmetic at WIDTH bits gives the same answer as the wide form.
  assign wrap_up      = q_i + step_w - limit_i - One;
  assign wrap_dn      = q_i + limit_i + One - step_w;
  assign out_of_range = q_i > limit_i;
  assign is_sat       = (mode_i == CNT_SAT);

  always_comb begin
    next_q_o = q_i;
    evt_o    = CntEvtNone;
    if (step_i == '0) begin
      next_q_o = q_i;
    end else if (out_of_range) begin
      // Limit was lowered under the count: treat as overflow regardless of direction.
      evt_o.ovf = 1'b1;
      next_q_o  = is_sat ? limit_i : '0;
    end else if (!down_i) begin
      if (sum_ext > {1'b0, limit_i}) begin
        evt_o.ovf = 1'b1;
        next_q_o  = is_sat ? limit_i : wrap_up;
      end else begin
        next_q_o = sum_ext[WIDTH-1:0];
      end
    end else begin
      if (step_w > q_i) begin
        evt_o.unf = 1'b1;
        next_q_o  = is_sat ? '0 : wrap_dn;
      end else begin
        next_q_o = q_i - step_w;
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable modulus and step, wrap or saturate, sticky
// overflow/underflow flags and a registered one-cycle event pulse.
module updown_mod_counter
  import fpu_cnt_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STEP_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  input  logic              i_en,
  input  logic              i_down,
  input  logic [STEP_W-1:0] i_step,
  input  logic [WIDTH-1:0]  i_limit,
  input  logic              i_sat,
  input  logic              i_flag_clr,
  output logic [WIDTH-1:0]  o_q,
  output logic              o_tc,
  output logic              o_ovf,
  output logic              o_unf,
  output logic              o_evt
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             evt_q, evt_d;

  logic [WIDTH-1:0] step_q;
  cnt_evt_t         step_evt;
  cnt_evt_t         edge_evt;

  updown_mod_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .q_i      (q_q),
    .step_i   (i_step),
    .limit_i  (i_limit),
    .down_i   (i_down),
    .mode_i   (cnt_mode_e'(i_sat)),
    .next_q_o (step_q),
    .evt_o    (step_evt)
  );

  // Clear and load take priority over counting and never raise events.
  always_comb begin
    q_d      = q_q;
    edge_evt = CntEvtNone;
    if (i_clr) begin
      q_d = '0;
    end else if (i_load) begin
      q_d = (i_load_val > i_limit) ? i_limit : i_load_val;
    end else if (i_en) begin
      q_d      = step_q;
      edge_evt = step_evt;
    end
  end

  // A coincident event beats the flag clear.
  always_comb begin
    ovf_d = edge_evt.ovf | (ovf_q & ~i_flag_clr);
    unf_d = edge_evt.unf | (unf_q & ~i_flag_clr);
    evt_d = edge_evt.ovf | edge_evt.unf;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      evt_q <= evt_d;
    end
  end

  assign o_q   = q_q;
  assign o_ovf = ovf_q;
  assign o_unf = unf_q;
  assign o_evt = evt_q;
  assign o_tc  = i_down ? (q_q == '0) : (q_q >= i_limit);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: vector table, directed corner sequences, and
// randomized traffic against an arithmetic reference model.
module tb_updown_mod_counter;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 4;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          load;
  logic [W-1:0]  load_val;
  logic          en;
  logic          down;
  logic [SW-1:0] step;
  logic [W-1:0]  limit;
  logic          sat;
  logic          flag_clr;
  logic [W-1:0]  q;
  logic          tc;
  logic          ovf;
  logic          unf;
  logic          evt;

  int n_checks;
  int n_errors;

  // Reference model state
  int m_q;
  bit m_ovf;
  bit m_unf;
  bit m_evt;

  updown_mod_counter #(
    .WIDTH  (W),
    .STEP_W (SW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clr      (clr),
    .i_load     (load),
    .i_load_val (load_val),
    .i_en       (en),
    .i_down     (down),
    .i_step     (step),
    .i_limit    (limit),
    .i_sat      (sat),
    .i_flag_clr (flag_clr),
    .o_q        (q),
    .o_tc       (tc),
    .o_ovf      (ovf),
    .o_unf      (unf),
    .o_evt      (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step contract: a counting step may wrap at most once.
  always @(posedge clk) begin
    if (rst_n && en && !clr && !load) begin
      assert (int'(step) <= int'(limit) + 1)
        else $error("step %0d exceeds limit+1 (%0d)", step, int'(limit) + 1);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          clr;
    bit          load;
    bit [W-1:0]  lv;
    bit          en;
    bit          down;
    bit [SW-1:0] st;
    bit [W-1:0]  lim;
    bit          sat;
    bit          fc;
    bit [W-1:0]  eq;
    bit          eovf;
    bit          eunf;
    bit          eevt;
    bit          etc;
  } vec_t;

  function automatic vec_t mk(bit c, bit l, bit [W-1:0] lv, bit e, bit d, bit [SW-1:0] st,
                              bit [W-1:0] lim, bit s, bit fc, bit [W-1:0] eq, bit eo,
                              bit eu, bit ee, bit et);
    vec_t v;
    v.clr = c;   v.load = l;  v.lv = lv;   v.en = e;    v.down = d;
    v.st = st;   v.lim = lim; v.sat = s;   v.fc = fc;   v.eq = eq;
    v.eovf = eo; v.eunf = eu; v.eevt = ee; v.etc = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clr = 0; load = 0; load_val = '0; en = 0; flag_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec rules in plain integer arithmetic, applied for the inputs about to be clocked.
  task automatic model_edge();
    int lim;
    int st;
    bit ev_o;
    bit ev_u;
    lim  = int'(limit);
    st   = int'(step);
    ev_o = 0;
    ev_u = 0;
    if (clr) begin
      m_q = 0;
    end else if (load) begin
      m_q = (int'(load_val) > lim) ? lim : int'(load_val);
    end else if (en && st != 0) begin
      if (m_q > lim) begin
        ev_o = 1;
        m_q  = sat ? lim : 0;
      end else if (!down) begin
        if (m_q + st > lim) begin
          ev_o = 1;
          m_q  = sat ? lim : m_q + st - (lim + 1);
        end else begin
          m_q = m_q + st;
        end
      end else begin
        if (st > m_q) begin
          ev_u = 1;
          m_q  = sat ? 0 : m_q + (lim + 1) - st;
        end else begin
          m_q = m_q - st;
        end
      end
    end
    m_ovf = ev_o | (m_ovf & ~flag_clr);
    m_unf = ev_u | (m_unf & ~flag_clr);
    m_evt = ev_o | ev_u;
  endtask

  task automatic chk_model(input int i);
    bit exp_tc;
    exp_tc = down ? (m_q == 0) : (m_q >= int'(limit));
    chk($sformatf("rnd%0d q", i), 32'(q), 32'(m_q));
    chk($sformatf("rnd%0d ovf", i), 32'(ovf), 32'(m_ovf));
    chk($sformatf("rnd%0d unf", i), 32'(unf), 32'(m_unf));
    chk($sformatf("rnd%0d evt", i), 32'(evt), 32'(m_evt));
    chk($sformatf("rnd%0d tc", i), 32'(tc), 32'(exp_tc));
  endtask

  vec_t tbl[17];

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    down = 1; step = 0; limit = 9; sat = 0;

    // Reset with down asserted
    rst_n = 0;
    #12;
    chk("rst q", 32'(q), 0);
    chk("rst ovf", 32'(ovf), 0);
    chk("rst unf", 32'(unf), 0);
    chk("rst evt", 32'(evt), 0);
    chk("rst tc", 32'(tc), 1);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d q", i), 32'(q), 0);
    end

    // Wrap-up run, flag clear, saturating down run, clr/load priority, set-beats-clear
    tbl[0]  = mk(0, 0, 0, 1, 0, 3, 9, 0, 0, 3, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 3, 9, 0, 0, 6, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 3, 9, 0, 0, 9, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 1, 0, 3, 9, 0, 0, 2, 1, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 3, 9, 0, 0, 2, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 3, 9, 0, 1, 2, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 5, 0, 1, 4, 9, 1, 0, 5, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 1, 1, 4, 9, 1, 0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 1, 4, 9, 1, 0, 0, 0, 1, 1, 1);
    tbl[9]  = mk(0, 0, 0, 1, 1, 4, 9, 1, 0, 0, 0, 1, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, 1, 4, 9, 1, 0, 0, 0, 1, 0, 1);
    tbl[11] = mk(1, 0, 0, 0, 0, 3, 9, 0, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 1, 7, 1, 0, 3, 9, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 9, 0, 0, 3, 9, 0, 0, 9, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 1, 0, 3, 9, 0, 0, 2, 1, 0, 1, 0);
    tbl[15] = mk(0, 1, 9, 0, 0, 3, 9, 0, 0, 9, 1, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 1, 0, 3, 9, 0, 1, 2, 1, 0, 1, 0);

    for (int i = 0; i < 17; i++) begin
      clr = tbl[i].clr;   load = tbl[i].load; load_val = tbl[i].lv;
      en = tbl[i].en;     down = tbl[i].down; step = tbl[i].st;
      limit = tbl[i].lim; sat = tbl[i].sat;   flag_clr = tbl[i].fc;
      tick();
      chk($sformatf("row%0d q", i), 32'(q), 32'(tbl[i].eq));
      chk($sformatf("row%0d ovf", i), 32'(ovf), 32'(tbl[i].eovf));
      chk($sformatf("row%0d unf", i), 32'(unf), 32'(tbl[i].eunf));
      chk($sformatf("row%0d evt", i), 32'(evt), 32'(tbl[i].eevt));
      chk($sformatf("row%0d tc", i), 32'(tc), 32'(tbl[i].etc));
    end

    // Limit lowered under the count, saturate then wrap
    for (int m = 0; m < 2; m++) begin
      idle_inputs();
      flag_clr = 1; load = 1; load_val = 200; limit = 255; down = 0; step = 1;
      sat = (m == 0);
      tick();
      chk($sformatf("oor%0d load", m), 32'(q), 200);
      idle_inputs();
      limit = 100; en = 1;
      tick();
      chk($sformatf("oor%0d q", m), 32'(q), (m == 0) ? 100 : 0);
      chk($sformatf("oor%0d ovf", m), 32'(ovf), 1);
      chk($sformatf("oor%0d evt", m), 32'(evt), 1);
    end

    // Reset asserted between edges while an event pulse is live
    idle_inputs();
    flag_clr = 1; load = 1; load_val = 255; limit = 255; sat = 0; down = 0; step = 1;
    tick();
    idle_inputs();
    en = 1;
    tick();
    chk("midrst pre evt", 32'(evt), 1);
    #2;
    rst_n = 0;
    #1;
    chk("midrst q", 32'(q), 0);
    chk("midrst ovf", 32'(ovf), 0);
    chk("midrst evt", 32'(evt), 0);
    @(negedge clk);
    rst_n = 1;
    en = 0;
    tick();
    chk("postrst evt", 32'(evt), 0);
    chk("postrst q", 32'(q), 0);

    // Randomized traffic against the model, from a fresh reset
    rst_n = 0;
    idle_inputs();
    #3;
    @(negedge clk);
    rst_n = 1;
    m_q = 0; m_ovf = 0; m_unf = 0; m_evt = 0;
    limit = 9;
    for (int i = 0; i < 600; i++) begin
      int max_st;
      if ($urandom_range(0, 15) == 0) begin
        limit = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                            : W'($urandom_range(0, 12));
      end
      max_st   = (int'(limit) + 1 > 15) ? 15 : int'(limit) + 1;
      step     = SW'($urandom_range(0, max_st));
      clr      = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom_range(0, 255));
      en       = ($urandom_range(0, 3) != 0);
      down     = $urandom_range(0, 1);
      sat      = $urandom_range(0, 1);
      flag_clr = ($urandom_range(0, 15) == 0);
      model_edge();
      tick();
      chk_model(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
